// File: rtl/qdrc_phy_burst_align.sv
// QDR read-path burst aligner: re-times half-cycle-late bits, calibrates read latency
// against the all-ones/all-zeros training word, then delays rd_en into rd_valid.
module qdrc_phy_burst_align #(
  parameter int DATA_WIDTH    = 18,
  parameter int MAX_LATENCY   = 15,
  parameter int LAT_WIDTH     = 4,
  parameter int CONFIRM_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] aligned,
  input  logic [DATA_WIDTH-1:0] q_rise,
  input  logic [DATA_WIDTH-1:0] q_fall,
  input  logic                  cal_start,
  output logic                  cal_rd_req,
  output logic                  cal_done,
  output logic                  cal_fail,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] d_rise,
  output logic [DATA_WIDTH-1:0] d_fall,
  output logic [LAT_WIDTH-1:0]  latency
);

  localparam int CNT_W = $clog2(MAX_LATENCY + 2);
  localparam int GAP_W = $clog2(MAX_LATENCY + 1);
  localparam int REP_W = $clog2(CONFIRM_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_PASS, S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]  dRise_q, dRise_d, dFall_q, dFall_d, qFallPrev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cntCur;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [REP_W-1:0]       rep_q, rep_d, repInc;
  logic [LAT_WIDTH-1:0]   meas_q, meas_d, lat_q, lat_d;
  logic                   done_q, done_d, fail_q, fail_d;
  logic [MAX_LATENCY-1:0] vldSr_q, vldSr_d;
  logic [MAX_LATENCY:0]   tap;
  logic                   match, timeout, latMismatch;

  // A late bit's rising half arrived in the previous cycle's fall slot.
  always_comb begin
    dRise_d = (aligned & q_rise) | (~aligned & qFallPrev_q);
    dFall_d = (aligned & q_fall) | (~aligned & q_rise);
    vldSr_d = {vldSr_q[MAX_LATENCY-2:0], rd_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dRise_q     <= '0;
      dFall_q     <= '0;
      qFallPrev_q <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      meas_q      <= '0;
      lat_q       <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      vldSr_q     <= '0;
    end else begin
      state_q     <= state_d;
      dRise_q     <= dRise_d;
      dFall_q     <= dFall_d;
      qFallPrev_q <= q_fall;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      rep_q       <= rep_d;
      meas_q      <= meas_d;
      lat_q       <= lat_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      vldSr_q     <= vldSr_d;
    end
  end

  assign match       = (&dRise_q) && !(|dFall_q);
  assign cntCur      = cnt_q + 1'b1;
  assign repInc      = rep_q + 1'b1;
  assign timeout     = cntCur > CNT_W'(MAX_LATENCY);
  assign latMismatch = cntCur != CNT_W'(meas_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cal_start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (timeout)
          state_d = S_FAIL;
        else if (match)
          state_d = (rep_q != '0 && latMismatch) ? S_FAIL : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(MAX_LATENCY))
          state_d = (repInc == REP_W'(CONFIRM_COUNT)) ? S_PASS : S_ISSUE;
      end
      S_PASS:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Calibration bookkeeping; the first read's latency is the reference for the rest.
  always_comb begin
    cnt_d  = cnt_q;
    gap_d  = gap_q;
    rep_d  = rep_q;
    meas_d = meas_q;
    lat_d  = lat_q;
    done_d = done_q;
    fail_d = fail_q;
    case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          done_d = 1'b0;
          fail_d = 1'b0;
          lat_d  = '0;
          rep_d  = '0;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cntCur;
        gap_d = '0;
        if (!timeout && match && rep_q == '0)
          meas_d = cntCur[LAT_WIDTH-1:0];
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(MAX_LATENCY))
          rep_d = repInc;
      end
      S_PASS: begin
        lat_d  = meas_q;
        done_d = 1'b1;
      end
      S_FAIL: begin
        fail_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign tap = {vldSr_q, rd_en};

  always_comb begin
    cal_rd_req = (state_q == S_ISSUE);
    cal_done   = done_q;
    cal_fail   = fail_q;
    latency    = lat_q;
    d_rise     = dRise_q;
    d_fall     = dFall_q;
    rd_valid   = done_q && !fail_q && tap[lat_q];
  end

endmodule

// File: tb/tb_qdrc_phy_burst_align.sv
// Directed bench for qdrc_phy_burst_align with a small read-return model
// that plays the training word back a programmable number of cycles after each request.
module tb_qdrc_phy_burst_align;

  logic        clk;
  logic        reset;
  logic [17:0] aligned;
  logic [17:0] q_rise;
  logic [17:0] q_fall;
  logic        cal_start;
  logic        cal_rd_req;
  logic        cal_done;
  logic        cal_fail;
  logic        rd_en;
  logic        rd_valid;
  logic [17:0] d_rise;
  logic [17:0] d_fall;
  logic [3:0]  latency;

  int compared = 0;
  int mismatched = 0;

  int latTable[4];
  bit respond = 1'b1;
  int age = 1000;
  int curLat = 0;
  int reqIdx = 0;
  logic [17:0] mRise, mFall;

  int nReq;
  int reqAt[8];
  int doneAt;
  logic [17:0] matchRise, matchFall;
  logic        seen;
  logic [14:0] vldVec;

  qdrc_phy_burst_align dut (
    .clk       (clk),
    .reset     (reset),
    .aligned   (aligned),
    .q_rise    (q_rise),
    .q_fall    (q_fall),
    .cal_start (cal_start),
    .cal_rd_req(cal_rd_req),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .d_rise    (d_rise),
    .d_fall    (d_fall),
    .latency   (latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track cycles since the last request; age N means N cycles after cal_rd_req.
  always @(posedge clk) begin
    if (reset) begin
      reqIdx = 0;
      age = 1000;
    end else begin
      if (cal_start) reqIdx = 0;
      if (cal_rd_req) begin
        curLat = (reqIdx < 4) ? latTable[reqIdx] : 0;
        reqIdx++;
        age = 1;
      end else if (age < 1000) begin
        age++;
      end
    end
  end

  // Drive q so the realigned word lands on d_* exactly curLat cycles after the request.
  always @(negedge clk) begin
    mRise = '0;
    mFall = '0;
    if (respond && curLat >= 2) begin
      if (age == curLat - 1)
        mRise = aligned;
      else if (age == curLat - 2)
        mFall = ~aligned;
    end
    q_rise = mRise;
    q_fall = mFall;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int budget);
    nReq = 0;
    doneAt = 0;
    matchRise = '0;
    matchFall = '1;
    for (int i = 0; i < 8; i++) reqAt[i] = 0;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (cal_rd_req) begin
        if (nReq < 8) reqAt[nReq] = c;
        nReq++;
      end
      if (c == 7) begin
        matchRise = d_rise;
        matchFall = d_fall;
      end
      if (cal_done) begin
        doneAt = c;
        break;
      end
      @(negedge clk);
    end
    checkOutput("cal_done_reached", {31'd0, cal_done}, 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_req"}, {31'd0, cal_rd_req}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, cal_done}, 32'd0);
    checkOutput({tag, "_fail"}, {31'd0, cal_fail}, 32'd0);
    checkOutput({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    checkOutput({tag, "_latency"}, {28'd0, latency}, 32'd0);
    checkOutput({tag, "_d_rise"}, {14'd0, d_rise}, 32'd0);
    checkOutput({tag, "_d_fall"}, {14'd0, d_fall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cal_start = 1'b0;
    rd_en = 1'b0;
    aligned = '1;
    latTable = '{6, 6, 6, 6};
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Fully aligned bus, every read returns at 6: four requests 23 cycles apart, pass.
    applyStimulus(200);
    checkOutput("pass_nreq", nReq, 4);
    checkOutput("pass_spacing01", reqAt[1] - reqAt[0], 23);
    checkOutput("pass_spacing23", reqAt[3] - reqAt[2], 23);
    checkOutput("pass_done_at", doneAt, 94);
    checkOutput("pass_fail", {31'd0, cal_fail}, 32'd0);
    checkOutput("pass_latency", {28'd0, latency}, 32'd6);
    checkOutput("pass_match_rise", {14'd0, matchRise}, 32'h3FFFF);

    // Three back-to-back reads come out as three valids exactly 6 cycles later.
    vldVec = '0;
    for (int j = 0; j < 15; j++) begin
      vldVec[j] = rd_valid;
      rd_en = (j < 3);
      @(negedge clk);
    end
    rd_en = 1'b0;
    checkOutput("rd_valid_window", {17'd0, vldVec}, 32'h01C0);

    // Mixed alignment: late bits must be stitched back into one coherent word.
    aligned = 18'h00F0F;
    @(negedge clk);
    applyStimulus(200);
    checkOutput("skew_match_rise", {14'd0, matchRise}, 32'h3FFFF);
    checkOutput("skew_match_fall", {14'd0, matchFall}, 32'h0);
    checkOutput("skew_fail", {31'd0, cal_fail}, 32'd0);
    checkOutput("skew_latency", {28'd0, latency}, 32'd6);

    // Third read returns one cycle late: calibration must fail and gate rd_valid.
    aligned = '1;
    latTable = '{6, 6, 7, 6};
    @(negedge clk);
    applyStimulus(200);
    checkOutput("mism_nreq", nReq, 3);
    checkOutput("mism_done_at", doneAt, 56);
    checkOutput("mism_fail", {31'd0, cal_fail}, 32'd1);
    checkOutput("mism_latency", {28'd0, latency}, 32'd0);
    seen = 1'b0;
    rd_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      rd_en = 1'b0;
      seen = seen | rd_valid;
    end
    checkOutput("mism_no_rd_valid", {31'd0, seen}, 32'd0);

    // Nothing ever comes back: fail once cnt passes 15 on the very first read.
    respond = 1'b0;
    latTable = '{6, 6, 6, 6};
    @(negedge clk);
    applyStimulus(200);
    checkOutput("tmo_nreq", nReq, 1);
    checkOutput("tmo_done_at", doneAt, 19);
    checkOutput("tmo_fail", {31'd0, cal_fail}, 32'd1);
    checkOutput("tmo_latency", {28'd0, latency}, 32'd0);

    // Reset just before the second read's match cycle, with cal_start held alongside it.
    respond = 1'b1;
    @(negedge clk);
    nReq = 0;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      if (cal_rd_req) nReq++;
      if (c < 29) @(negedge clk);
    end
    checkOutput("rst_nreq_before", nReq, 2);
    reset = 1'b1;
    cal_start = 1'b1;
    @(negedge clk);
    checkAllZero("rst_mid");
    reset = 1'b0;
    cal_start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      seen = seen | cal_rd_req | cal_done;
    end
    checkOutput("rst_stays_idle", {31'd0, seen}, 32'd0);
    applyStimulus(200);
    checkOutput("rst_redo_nreq", nReq, 4);
    checkOutput("rst_redo_done_at", doneAt, 94);
    checkOutput("rst_redo_fail", {31'd0, cal_fail}, 32'd0);
    checkOutput("rst_redo_latency", {28'd0, latency}, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
